// File: rtl/hdmi_audio_pkg.sv
// Shared types and constants for the HDMI 2-channel audio sample packet path.
package hdmi_audio_pkg;

  localparam int CHANNEL_STATUS_LENGTH = 192;
  localparam int SUBPACKETS = 4;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } audio_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY
  } sched_state_t;

endpackage

// File: rtl/audio_sample_packet_scheduler_if.sv
// Sample-input handshake, packet-picker handshake and packet-field outputs of the scheduler.
interface audio_sample_packet_scheduler_if;

  // A pair moves when sample_valid & sample_ready are both high on a clk_pixel edge;
  // a packet is taken when packet_grant is high while packet_request is high.
  logic         sample_valid;
  logic         sample_ready;
  logic [23:0]  sample_l;
  logic [23:0]  sample_r;
  logic         packet_request;
  logic         packet_grant;
  logic [7:0]   frame_counter;
  logic [191:0] audio_sample_word;
  logic [3:0]   audio_sample_word_present;
  logic [7:0]   valid_bit;
  logic [7:0]   user_data_bit;
  logic         overflow;

  modport master (
    output sample_valid, sample_l, sample_r, packet_grant,
    input  sample_ready, packet_request, frame_counter, audio_sample_word,
    input  audio_sample_word_present, valid_bit, user_data_bit, overflow
  );

  modport slave (
    input  sample_valid, sample_l, sample_r, packet_grant,
    output sample_ready, packet_request, frame_counter, audio_sample_word,
    output audio_sample_word_present, valid_bit, user_data_bit, overflow
  );

endinterface

// File: rtl/audio_pair_fifo.sv
// Synchronous L/R pair FIFO with a 4-entry parallel peek and a multi-entry pop.
module audio_pair_fifo
  import hdmi_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  audio_pair_t                   push_data,
  input  logic [2:0]                    pop_n,
  output audio_pair_t [SUBPACKETS-1:0]  peek,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);

  audio_pair_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;

  // Pop count is trusted to be <= count; the caller derives it from count.
  always_comb begin
    push_ok  = push && (count_q != (AW+1)'(DEPTH));
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    for (int i = 0; i < SUBPACKETS; i++) peek[i] = mem_q[rd_ptr_q + AW'(i)];
  end

  assign count = count_q;

endmodule

// File: rtl/audio_sample_packet_scheduler.sv
// Buffers L/R pairs, requests an audio sample packet when 4 pairs are ready or a partial set
// has waited long enough, and drains up to 4 pairs per grant while tracking the 192-frame block.
module audio_sample_packet_scheduler
  import hdmi_audio_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_WAIT_CYCLES = 256,
  parameter int SAMPLE_WIDTH    = 24
) (
  input  logic                            clk_pixel,
  input  logic                            reset,
  audio_sample_packet_scheduler_if.slave  bus,
  output sched_state_t                    state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(MAX_WAIT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(MAX_WAIT_CYCLES - 1);
  localparam int SP_W = 2 * SAMPLE_WIDTH;

  sched_state_t                 state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [7:0]                   blk_q, blk_d;
  logic [7:0]                   fc_q, fc_d;
  logic [SUBPACKETS*SP_W-1:0]   word_q, word_d;
  logic [3:0]                   present_q, present_d;
  logic                         ovf_q, ovf_d;

  logic [CW-1:0]                fifo_count, count_nx;
  audio_pair_t [SUBPACKETS-1:0] peek;
  audio_pair_t                  push_pair;
  logic                         push, grant;
  logic [2:0]                   n_avail, pop_n;
  logic [8:0]                   blk_sum;

  assign bus.sample_ready = (fifo_count != CW'(FIFO_DEPTH));
  assign push_pair        = {bus.sample_l, bus.sample_r};
  assign push             = bus.sample_valid && bus.sample_ready;
  assign n_avail          = (fifo_count >= CW'(SUBPACKETS)) ? 3'(SUBPACKETS) : fifo_count[2:0];
  assign grant            = bus.packet_grant && (state_q == READY);
  assign pop_n            = grant ? n_avail : 3'd0;
  assign count_nx         = fifo_count + CW'(push) - CW'(pop_n);

  audio_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_pixel),
    .rst       (reset),
    .push      (push),
    .push_data (push_pair),
    .pop_n     (pop_n),
    .peek      (peek),
    .count     (fifo_count)
  );

  // Decisions look at the post-edge count so the request rises on the edge the 4th pair lands.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (count_nx != '0) state_d = FILL;
      end
      FILL: begin
        timer_d = (timer_q == T_LAST) ? timer_q : timer_q + TW'(1);
        if (count_nx >= CW'(SUBPACKETS) || timer_q == T_LAST) state_d = READY;
      end
      READY: begin
        if (grant) begin
          timer_d = '0;
          if (count_nx >= CW'(SUBPACKETS)) state_d = READY;
          else if (count_nx != '0)         state_d = FILL;
          else                             state_d = IDLE;
        end else if (timer_q != T_LAST) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_d     = blk_q;
    fc_d      = fc_q;
    word_d    = word_q;
    present_d = present_q;
    ovf_d     = ovf_q | (bus.sample_valid & ~bus.sample_ready);
    blk_sum   = {1'b0, blk_q} + 9'(pop_n);
    if (grant) begin
      fc_d      = blk_q;
      blk_d     = (blk_sum >= 9'(CHANNEL_STATUS_LENGTH)) ?
                  8'(blk_sum - 9'(CHANNEL_STATUS_LENGTH)) : blk_sum[7:0];
      present_d = ~(4'hF << n_avail);
      word_d    = '0;
      for (int i = 0; i < SUBPACKETS; i++) begin
        if (3'(i) < n_avail) word_d[i*SP_W +: SP_W] = {peek[i].r, peek[i].l};
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      blk_q     <= '0;
      fc_q      <= '0;
      word_q    <= '0;
      present_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      blk_q     <= blk_d;
      fc_q      <= fc_d;
      word_q    <= word_d;
      present_q <= present_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.packet_request            = (state_q == READY);
  assign bus.frame_counter             = fc_q;
  assign bus.audio_sample_word         = word_q;
  assign bus.audio_sample_word_present = present_q;
  assign bus.valid_bit                 = 8'h00;
  assign bus.user_data_bit             = 8'h00;
  assign bus.overflow                  = ovf_q;
  assign state_dbg                     = state_q;

endmodule

// File: doc/audio_sample_packet_scheduler.md
Name: audio_sample_packet_scheduler

Overview:
Sequences the 2-channel audio sample packet datapath in the HDMI transmitter. Buffers incoming L/R sample pairs in a small FIFO and decides when to emit an audio sample packet. On grant from the packet picker it drains 1-4 pairs into the packet-field outputs. It also maintains the 192-frame IEC 60958 channel-status block counter that the packet formatter consumes.

Parameters:
FIFO_DEPTH, 8, sample-pair FIFO depth; power of two, minimum 4
MAX_WAIT_CYCLES, 256, clk_pixel cycles a partial (<4 pair) FIFO waits before a packet is requested anyway
SAMPLE_WIDTH, 24, audio sample word width; fixed at 24

Ports:
clk_pixel  in  1  pixel clock; single clock domain
reset  in  1  asynchronous, active-high reset
sample_valid  in  1  new L/R pair offered
sample_ready  out  1  FIFO can accept; transfer = sample_valid & sample_ready
sample_l  in  24  left sample word
sample_r  in  24  right sample word
packet_request  out  1  packet available for scheduling
packet_grant  in  1  picker consumes the current request this cycle
frame_counter  out  8  channel-status index of subpacket 0, range 0..191
audio_sample_word  out  192  {sp3R,sp3L,...,sp0R,sp0L}, 24 b each, sp0L at [23:0]
audio_sample_word_present  out  4  subpacket-valid mask
valid_bit  out  8  per subpacket {R,L}; always 0
user_data_bit  out  8  always 0
overflow  out  1  sticky: pair offered while FIFO full; cleared only by reset

Behaviour:
- Reset (async assert, sync release) clears:
  - FIFO pointers, count = 0, wait timer = 0
  - frame_counter = 0, audio_sample_word = 0, audio_sample_word_present = 0
  - packet_request = 0, overflow = 0
  - sample_ready = 1 once reset deasserts
- FIFO:
  - sample_ready = (count != FIFO_DEPTH)
  - Push on transfer. Sample offered when full: dropped, overflow set.
  - Count width clog2(FIFO_DEPTH)+1.
- FSM:
  - IDLE: count == 0. Timer held at 0, packet_request = 0. Go to FILL when count becomes >= 1.
  - FILL: timer increments each cycle. Go to READY when count >= 4 or timer == MAX_WAIT_CYCLES-1.
  - READY: packet_request = 1. On packet_grant, pop n = min(count,4) pairs and reset the timer.
    - Next state is READY if the remaining count is >= 4.
    - Otherwise FILL if the remaining count is > 0, else IDLE.
- packet_grant is ignored unless packet_request = 1. Grant is single-cycle; request drops the cycle after a grant when the next state is not READY.
- Pop latency: on the grant edge, pairs 0..n-1 load into subpackets 0..n-1.
  - audio_sample_word_present becomes (1<<n)-1.
  - Unused subpacket words load 0.
  - Outputs are registered and held stable until the next grant.
- frame_counter update on grant: loads the pre-grant block counter value, and the internal block counter advances by n.
  - Wrap rule: next = (cnt + n >= 192) ? cnt + n - 192 : cnt + n.
  - Compute at 9 bits to avoid truncation.
- Push and pop in the same cycle: count_next = count + push - n. A full FIFO with a simultaneous grant still refuses the push, because sample_ready is registered off the current count.
- Timer saturates at MAX_WAIT_CYCLES-1 while in READY awaiting grant.
- Reset mid-packet discards FIFO contents; no partial packet is emitted after reset.

Decomposition:
- Package hdmi_audio_pkg:
  - localparam CHANNEL_STATUS_LENGTH = 192
  - localparam SUBPACKETS = 4
  - typedef audio_pair_t = struct {logic [23:0] l, r;}
  - sched_state_t enum {IDLE, FILL, READY}
- Sub-module audio_pair_fifo:
  - Synchronous FIFO of audio_pair_t with 4-entry parallel read peek.
  - Pop-count input 0..4 and count output.
- The top level holds the FSM, timer, block counter and output registers.

Test Plan:
- Push 4 pairs back-to-back (L=0x000001..4, R=0x100001..4), then grant:
  - packet_request rises the cycle count reaches 4; after the grant, present = 4'b1111.
  - sp0L = 0x000001, sp3R = 0x100004, frame_counter = 0, next block counter 4.
- Push 1 pair, no further input, MAX_WAIT_CYCLES = 16:
  - request asserts 16 cycles after entering FILL.
  - grant gives present = 4'b0001, sp1..3 words = 0, state returns to IDLE.
- Wrap: issue 47 full packets (188 frames), then push 4 more and grant:
  - frame_counter = 188, next = 0.
  - With 3 pairs instead: frame_counter = 188, next = 191; then 4 more pairs give 191 -> 3.
- Fill FIFO_DEPTH = 8 with no grant, then offer a 9th pair:
  - sample_ready = 0, pair dropped, overflow = 1 and held through later grants.
- Count 5, push and grant in the same cycle: count becomes 2, request drops, state FILL.
- Assert reset asynchronously while in READY with count 6: all outputs zero immediately, and frame_counter restarts at 0 on the next packet.
